// File: rtl/csi_capture_ctrl.sv
// CSI capture sequencer: sensor power/reset sequencing, frame arming, RAW10 unpacker gating,
// line/group counting against programmed dimensions, sticky status and IRQ over Wishbone.
module csi_capture_ctrl #(
  parameter int H_W     = 11,
  parameter int V_W     = 11,
  parameter int PWR_DLY = 1000,
  parameter int RST_DLY = 200
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        fsync_i,
  input  logic        lsync_i,
  input  logic        pix_valid_i,
  output logic        cam_pwr_en_o,
  output logic        cam_reset_o,
  output logic        cam_xmaster_o,
  output logic        cap_en_o,
  output logic        irq_o
);

  typedef enum logic [2:0] {
    S_OFF = 3'd0, S_PWR_UP = 3'd1, S_RST_REL = 3'd2,
    S_IDLE = 3'd3, S_WAIT_FS = 3'd4, S_CAPTURE = 3'd5
  } state_t;

  localparam int DLY_MAX = (PWR_DLY > RST_DLY) ? PWR_DLY : RST_DLY;
  localparam int DLY_W   = $clog2(DLY_MAX + 1);

  state_t           r_state, w_nxt;
  logic [DLY_W-1:0] r_dly;
  logic             r_ack;
  logic [31:0]      r_dat;
  logic             r_pwr_on, r_cont, r_xmaster;
  logic [2:0]       r_irq_en;
  logic [V_W-1:0]   r_exp_lines, r_lines, r_cnt_lines, w_lines_nx;
  logic [H_W-1:0]   r_exp_grp, r_grp, r_last_grp, r_cnt_grp;
  logic             r_done, r_line_err, r_frame_err, r_irq;
  logic             r_fs_q, r_ls_q;

  logic        w_req, w_wr, w_arm;
  logic [1:0]  w_reg;
  logic [31:0] w_mask, w_cfg_rd, w_cfg_new, w_cnt_rd, w_rd;
  logic [2:0]  w_clr;
  logic        w_fs_rise, w_fs_fall, w_ls_fall, w_cap;
  logic        w_set_done, w_set_lerr, w_set_ferr;

  assign w_req  = wbs_stb_i & wbs_cyc_i & ~r_ack;
  assign w_wr   = w_req & wbs_we_i;
  assign w_reg  = wbs_adr_i[3:2];
  assign w_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign w_arm  = w_wr & (w_reg == 2'd0) & wbs_sel_i[0] & wbs_dat_i[1];
  assign w_clr  = (w_wr && w_reg == 2'd2 && wbs_sel_i[0]) ? wbs_dat_i[2:0] : 3'b000;

  always_comb begin
    w_cfg_rd = '0;
    w_cfg_rd[V_W+15:16] = r_exp_lines;
    w_cfg_rd[H_W-1:0]   = r_exp_grp;
    w_cnt_rd = '0;
    w_cnt_rd[V_W+15:16] = r_cnt_lines;
    w_cnt_rd[H_W-1:0]   = r_cnt_grp;
    w_cfg_new = (w_cfg_rd & ~w_mask) | (wbs_dat_i & w_mask);
    case (w_reg)
      2'd0:    w_rd = {25'd0, r_irq_en, r_xmaster, r_cont, 1'b0, r_pwr_on};
      2'd1:    w_rd = w_cfg_rd;
      2'd2:    w_rd = {25'd0, r_state, (r_state == S_WAIT_FS) || (r_state == S_CAPTURE),
                       r_frame_err, r_line_err, r_done};
      default: w_rd = w_cnt_rd;
    endcase
  end

  assign w_cap     = (r_state == S_CAPTURE);
  assign w_fs_rise = fsync_i & ~r_fs_q;
  assign w_fs_fall = ~fsync_i & r_fs_q;
  assign w_ls_fall = ~lsync_i & r_ls_q;
  // a line ending in the frame-end cycle is already included here
  assign w_lines_nx = (w_ls_fall && r_lines != '1) ? r_lines + 1'b1 : r_lines;

  assign w_set_done = w_cap & w_fs_fall;
  assign w_set_ferr = w_cap & w_fs_fall & (w_lines_nx != r_exp_lines);
  assign w_set_lerr = w_cap & w_ls_fall & (r_grp != r_exp_grp);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_OFF:     if (r_pwr_on) w_nxt = S_PWR_UP;
      S_PWR_UP:  if (r_dly == DLY_W'(PWR_DLY - 1)) w_nxt = S_RST_REL;
      S_RST_REL: if (r_dly == DLY_W'(RST_DLY - 1)) w_nxt = S_IDLE;
      S_IDLE:    if (w_arm) w_nxt = S_WAIT_FS;
      S_WAIT_FS: if (w_fs_rise) w_nxt = S_CAPTURE;
      S_CAPTURE: if (w_fs_fall) w_nxt = r_cont ? S_WAIT_FS : S_IDLE;
      default:   w_nxt = S_OFF;
    endcase
    if (!r_pwr_on) w_nxt = S_OFF;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      r_state     <= S_OFF;
      r_dly       <= '0;
      r_ack       <= 1'b0;
      r_dat       <= '0;
      r_pwr_on    <= 1'b0;
      r_cont      <= 1'b0;
      r_xmaster   <= 1'b0;
      r_irq_en    <= '0;
      r_exp_lines <= '0;
      r_exp_grp   <= '0;
      r_lines     <= '0;
      r_grp       <= '0;
      r_last_grp  <= '0;
      r_cnt_lines <= '0;
      r_cnt_grp   <= '0;
      r_done      <= 1'b0;
      r_line_err  <= 1'b0;
      r_frame_err <= 1'b0;
      r_irq       <= 1'b0;
      r_fs_q      <= 1'b0;
      r_ls_q      <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_dly   <= (w_nxt != r_state) ? '0 : r_dly + 1'b1;
      r_ack   <= w_req;
      r_dat   <= (w_req && !wbs_we_i) ? w_rd : '0;
      r_fs_q  <= fsync_i;
      r_ls_q  <= lsync_i;

      if (w_wr && w_reg == 2'd0 && wbs_sel_i[0]) begin
        r_pwr_on  <= wbs_dat_i[0];
        r_cont    <= wbs_dat_i[2];
        r_xmaster <= wbs_dat_i[3];
        r_irq_en  <= wbs_dat_i[6:4];
      end
      if (w_wr && w_reg == 2'd1) begin
        r_exp_lines <= w_cfg_new[V_W+15:16];
        r_exp_grp   <= w_cfg_new[H_W-1:0];
      end

      if (r_state == S_WAIT_FS && w_fs_rise) begin
        r_lines    <= '0;
        r_grp      <= '0;
        r_last_grp <= '0;
      end else if (w_cap) begin
        if (w_ls_fall) begin
          r_lines    <= w_lines_nx;
          r_grp      <= '0;
          r_last_grp <= r_grp;
        end else if (lsync_i && pix_valid_i && r_grp != '1) begin
          r_grp <= r_grp + 1'b1;
        end
        // group field reports the last completed line of the frame
        if (w_fs_fall) begin
          r_cnt_lines <= w_lines_nx;
          r_cnt_grp   <= w_ls_fall ? r_grp : r_last_grp;
        end
      end

      r_done      <= w_set_done | (r_done      & ~w_clr[0]);
      r_line_err  <= w_set_lerr | (r_line_err  & ~w_clr[1]);
      r_frame_err <= w_set_ferr | (r_frame_err & ~w_clr[2]);
      r_irq       <= |({r_frame_err, r_line_err, r_done} & r_irq_en);
    end
  end

  assign wbs_ack_o     = r_ack;
  assign wbs_dat_o     = r_dat;
  assign cam_pwr_en_o  = (r_state != S_OFF);
  assign cam_reset_o   = (r_state == S_OFF) || (r_state == S_PWR_UP);
  assign cam_xmaster_o = r_xmaster;
  assign cap_en_o      = w_cap;
  assign irq_o         = r_irq;

endmodule

// File: tb/tb_csi_capture_ctrl.sv
// Directed bench for csi_capture_ctrl: expected register reads are queued before each read
// and checked when the ack returns; pin levels are checked directly.
module tb_csi_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, dat = '0;
  logic        ack;
  logic [31:0] dat_o;
  logic        fs = 1'b0, ls = 1'b0, pv = 1'b0;
  logic        pwr_en, cam_rst, xmaster, cap_en, irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  localparam logic [31:0] A_CTRL = 32'h0, A_CFG = 32'h4, A_STS = 32'h8, A_CNT = 32'hC;

  csi_capture_ctrl #(.H_W(11), .V_W(11), .PWR_DLY(4), .RST_DLY(3)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .fsync_i(fs), .lsync_i(ls), .pix_valid_i(pv),
    .cam_pwr_en_o(pwr_en), .cam_reset_o(cam_rst), .cam_xmaster_o(xmaster),
    .cap_en_o(cap_en), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sts(input int st, input bit busy, input bit fe,
                                      input bit le, input bit dn);
    return {25'd0, 3'(st), busy, fe, le, dn};
  endfunction

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd);
    logic ok;
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat = d; sel = s;
    ok = 1'b0; rd = '0;
    for (int i = 0; i < 8; i++) begin
      cyc1();
      if (ack) begin
        ok = 1'b1;
        rd = dat_o;
        break;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    chk("wb_ack", {31'd0, ok}, 32'd1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    logic [31:0] rd;
    wb_xfer(1'b1, a, d, s, rd);
  endtask

  task automatic expect_rd(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic rd_chk(input logic [31:0] a);
    logic [31:0] rd;
    wb_xfer(1'b0, a, 32'h0, 4'hF, rd);
    if (exp_q.size() == 0) chk("scoreboard_empty", 32'd0, 32'd1);
    else chk(tag_q.pop_front(), rd, exp_q.pop_front());
  endtask

  // short_idx selects a 7-group line; simul drops fsync with the last lsync
  task automatic send_frame(input int nl, input int short_idx, input bit simul);
    fs = 1'b1;
    repeat (3) cyc1();
    for (int l = 0; l < nl; l++) begin
      ls = 1'b1; pv = 1'b1;
      repeat ((l == short_idx) ? 7 : 8) cyc1();
      ls = 1'b0; pv = 1'b0;
      if (simul && l == nl - 1) fs = 1'b0;
      repeat (2) cyc1();
    end
    fs = 1'b0;
    repeat (3) cyc1();
  endtask

  initial begin
    repeat (3) cyc1();
    chk("rst_cam_reset", {31'd0, cam_rst}, 32'd1);
    chk("rst_pwr_en", {31'd0, pwr_en}, 32'd0);
    chk("rst_cap_en", {31'd0, cap_en}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    rst_n = 1'b1;
    cyc1();
    expect_rd("rst_ctrl", 32'h0);  rd_chk(A_CTRL);
    expect_rd("rst_cfg", 32'h0);   rd_chk(A_CFG);
    expect_rd("rst_status", 32'h0); rd_chk(A_STS);
    expect_rd("rst_count", 32'h0); rd_chk(A_CNT);

    // power sequence
    wr(A_CTRL, 32'h1);
    for (int i = 0; i < 4; i++) begin
      cyc1();
      chk("pwr_up_en", {31'd0, pwr_en}, 32'd1);
      chk("pwr_up_rst", {31'd0, cam_rst}, 32'd1);
    end
    cyc1();
    chk("rst_rel_rst", {31'd0, cam_rst}, 32'd0);
    chk("rst_rel_en", {31'd0, pwr_en}, 32'd1);
    repeat (3) cyc1();
    expect_rd("pwr_idle", sts(3, 0, 0, 0, 0)); rd_chk(A_STS);

    // clean frame
    wr(A_CFG, 32'h0004_0008);
    wr(A_CTRL, 32'h13);
    expect_rd("ctrl_arm_rd0", 32'h11); rd_chk(A_CTRL);
    expect_rd("armed", sts(4, 1, 0, 0, 0)); rd_chk(A_STS);
    send_frame(4, -1, 1'b0);
    expect_rd("clean_status", sts(3, 0, 0, 0, 1)); rd_chk(A_STS);
    expect_rd("clean_count", 32'h0004_0008); rd_chk(A_CNT);
    chk("clean_irq", {31'd0, irq}, 32'd1);
    chk("clean_cap_en", {31'd0, cap_en}, 32'd0);

    // short line
    wr(A_STS, 32'h7);
    wr(A_CTRL, 32'h13);
    send_frame(4, 2, 1'b0);
    expect_rd("short_status", sts(3, 0, 0, 1, 1)); rd_chk(A_STS);
    wr(A_STS, 32'h7);
    expect_rd("w1c_status", sts(3, 0, 0, 0, 0)); rd_chk(A_STS);
    cyc1();
    chk("w1c_irq", {31'd0, irq}, 32'd0);

    // continuous mode, 2 frames
    wr(A_CTRL, 32'h17);
    send_frame(4, -1, 1'b0);
    expect_rd("cont_f1_status", sts(4, 1, 0, 0, 1)); rd_chk(A_STS);
    send_frame(3, -1, 1'b0);
    expect_rd("cont_f2_status", sts(4, 1, 1, 0, 1)); rd_chk(A_STS);
    expect_rd("cont_f2_count", 32'h0003_0008); rd_chk(A_CNT);

    // power off mid-capture, status kept
    fs = 1'b1;
    repeat (3) cyc1();
    ls = 1'b1; pv = 1'b1;
    repeat (2) cyc1();
    wr(A_CTRL, 32'h14);
    cyc1();
    chk("off_cap_en", {31'd0, cap_en}, 32'd0);
    chk("off_pwr_en", {31'd0, pwr_en}, 32'd0);
    chk("off_cam_rst", {31'd0, cam_rst}, 32'd1);
    ls = 1'b0; pv = 1'b0; fs = 1'b0;
    repeat (3) cyc1();
    expect_rd("off_status", sts(0, 0, 1, 0, 1)); rd_chk(A_STS);
    wr(A_CTRL, 32'h16);
    repeat (2) cyc1();
    expect_rd("off_arm_ignored", sts(0, 0, 1, 0, 1)); rd_chk(A_STS);
    expect_rd("off_ctrl", 32'h14); rd_chk(A_CTRL);
    wr(A_STS, 32'h7);

    // simultaneous line/frame end
    wr(A_CTRL, 32'h11);
    repeat (12) cyc1();
    expect_rd("repwr_idle", sts(3, 0, 0, 0, 0)); rd_chk(A_STS);
    wr(A_CTRL, 32'h13);
    send_frame(4, -1, 1'b1);
    expect_rd("simul_status", sts(3, 0, 0, 0, 1)); rd_chk(A_STS);
    expect_rd("simul_count", 32'h0004_0008); rd_chk(A_CNT);
    chk("simul_irq", {31'd0, irq}, 32'd1);

    // byte-select write touches only the selected byte
    wr(A_CFG, 32'hFFFF_FFFF, 4'b0001);
    expect_rd("sel_cfg", 32'h0004_00FF); rd_chk(A_CFG);
    chk("xmaster", {31'd0, xmaster}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
